// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control sequencer.
//   alu_ctrl_e  : 4-bit ALU control codes driven to the datapath
//   ALUOP_*     : main-decoder ALU_Op encodings
//   FN_*        : funct field values decoded when ALU_Op selects funct
//   lat_class_e : latency class of a control code (single / mul / div)
//   lat_class() : maps a control code to its latency class
package alu_pkg;

  typedef enum logic [3:0] {
    CTRL_NONE   = 4'b0000,  // undefined funct
    CTRL_ADD_LS = 4'b0001,  // add for load/store address
    CTRL_SUB_BR = 4'b0010,  // subtract for branch compare
    CTRL_ADD    = 4'b0011,
    CTRL_SUB    = 4'b0100,
    CTRL_MUL    = 4'b0101,
    CTRL_DIV    = 4'b0110,
    CTRL_OR     = 4'b0111,
    CTRL_AND    = 4'b1000,
    CTRL_XOR    = 4'b1001,
    CTRL_SLL    = 4'b1010,
    CTRL_SRL    = 4'b1011,
    CTRL_SLT    = 4'b1100,
    CTRL_REM    = 4'b1101,
    CTRL_SRA    = 4'b1110
  } alu_ctrl_e;

  localparam int unsigned ALUOP_ADD   = 0;
  localparam int unsigned ALUOP_SUB   = 1;
  localparam int unsigned ALUOP_SLT   = 2;
  localparam int unsigned ALUOP_FUNCT = 3;

  localparam int unsigned FN_ADD = 0;
  localparam int unsigned FN_SUB = 1;
  localparam int unsigned FN_MUL = 2;
  localparam int unsigned FN_DIV = 3;
  localparam int unsigned FN_OR  = 4;
  localparam int unsigned FN_AND = 5;
  localparam int unsigned FN_XOR = 6;
  localparam int unsigned FN_SLL = 7;
  localparam int unsigned FN_SRL = 8;
  localparam int unsigned FN_SLT = 9;
  localparam int unsigned FN_REM = 10;
  localparam int unsigned FN_SRA = 11;

  typedef enum logic [1:0] {
    LAT_SINGLE,
    LAT_MUL,
    LAT_DIV
  } lat_class_e;

  function automatic lat_class_e lat_class(input alu_ctrl_e code);
    case (code)
      CTRL_MUL:           return LAT_MUL;
      CTRL_DIV, CTRL_REM: return LAT_DIV;
      default:            return LAT_SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_lut.sv
// Combinational ALU control decode.
//   alu_op  : main-decoder ALU_Op
//   funct   : instruction funct field (used only when alu_op selects funct)
//   code    : ALU control code (CTRL_NONE for an undefined funct)
//   illegal : funct-decoded op with an undefined funct value
//   lat     : latency class of the decoded code
module alu_ctrl_lut
  import alu_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int OP_W    = 2
) (
  input  logic [OP_W-1:0]    alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output alu_ctrl_e          code,
  output logic               illegal,
  output lat_class_e         lat
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    code    = CTRL_NONE;
    illegal = 1'b0;
    case (alu_op)
      OP_W'(ALUOP_ADD): code = CTRL_ADD_LS;
      OP_W'(ALUOP_SUB): code = CTRL_SUB_BR;
      OP_W'(ALUOP_SLT): code = CTRL_SLT;
      OP_W'(ALUOP_FUNCT): begin
        case (funct)
          FUNCT_W'(FN_ADD): code = CTRL_ADD;
          FUNCT_W'(FN_SUB): code = CTRL_SUB;
          FUNCT_W'(FN_MUL): code = CTRL_MUL;
          FUNCT_W'(FN_DIV): code = CTRL_DIV;
          FUNCT_W'(FN_OR):  code = CTRL_OR;
          FUNCT_W'(FN_AND): code = CTRL_AND;
          FUNCT_W'(FN_XOR): code = CTRL_XOR;
          FUNCT_W'(FN_SLL): code = CTRL_SLL;
          FUNCT_W'(FN_SRL): code = CTRL_SRL;
          FUNCT_W'(FN_SLT): code = CTRL_SLT;
          FUNCT_W'(FN_REM): code = CTRL_REM;
          FUNCT_W'(FN_SRA): code = CTRL_SRA;
          default:          illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
    lat = lat_class(code);
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU control sequencer: decodes alu_op/funct on a valid/ready handshake,
// holds multi-cycle ops (mul, div, rem) for their latency while raising
// busy, then presents the registered control code until the consumer takes it.
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : synchronous abort back to idle
//   in_valid/in_ready     : decode request handshake (alu_op, funct)
//   out_valid/out_ready   : result handshake (alu_control, illegal)
//   busy                  : multi-cycle operation in progress
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int FUNCT_W    = 6,
  parameter int OP_W       = 2,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  alu_control,
  output logic               illegal,
  output logic               busy
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULTI,
    S_ISSUE
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;

  alu_ctrl_e  dec_code;
  logic       dec_illegal;
  lat_class_e dec_lat;
  int         dec_cycles;
  logic       accept;

  alu_ctrl_lut #(
    .FUNCT_W (FUNCT_W),
    .OP_W    (OP_W)
  ) u_lut (
    .alu_op  (alu_op),
    .funct   (funct),
    .code    (dec_code),
    .illegal (dec_illegal),
    .lat     (dec_lat)
  );

  always_comb begin
    case (dec_lat)
      LAT_MUL: dec_cycles = MUL_CYCLES;
      LAT_DIV: dec_cycles = DIV_CYCLES;
      default: dec_cycles = 1;
    endcase
  end

  // In ISSUE a new request may only enter when the held result leaves in the
  // same cycle, which gives back-to-back single-cycle ops with no bubble.
  assign in_ready = !flush && ((state == S_IDLE) || (state == S_ISSUE && out_ready));
  assign accept   = in_valid && in_ready;

  // NOTE: all state and output registers use nonblocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      alu_control <= '0;
      illegal     <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else if (flush) begin
      state       <= S_IDLE;
      cnt         <= '0;
      alu_control <= '0;
      illegal     <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else if (accept) begin
      // Only reachable from IDLE or ISSUE; decode is captured at this edge.
      alu_control <= CTRL_W'(dec_code);
      illegal     <= dec_illegal;
      if (dec_cycles == 1) begin
        state     <= S_ISSUE;
        out_valid <= 1'b1;
        busy      <= 1'b0;
      end else begin
        // MULTI lasts latency-1 cycles; counter reaching 0 marks the last one.
        state     <= S_MULTI;
        cnt       <= CNT_W'(dec_cycles - 2);
        out_valid <= 1'b0;
        busy      <= 1'b1;
      end
    end else begin
      case (state)
        S_MULTI: begin
          if (cnt == '0) begin
            state     <= S_ISSUE;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_ISSUE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model that
// tracks one outstanding result and the cycles remaining until it is valid.
module tb_alu_op_sequencer;

  localparam int MUL_C = 4;
  localparam int DIV_C = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] alu_op = 2'd0;
  logic [5:0] funct = 6'd0;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] alu_control;
  logic       illegal;
  logic       busy;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .FUNCT_W    (6),
    .OP_W       (2),
    .CTRL_W     (4),
    .MUL_CYCLES (MUL_C),
    .DIV_CYCLES (DIV_C)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .funct       (funct),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_control (alu_control),
    .illegal     (illegal),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: one outstanding result, cycles until it is valid.
  bit         m_has = 1'b0;
  bit         m_ill = 1'b0;
  int         m_rem = 0;
  logic [3:0] m_code = 4'd0;
  int         busy_seen = 0;
  int         valid_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {illegal, code}. Funct ops 0..11 map to codes 3..14 in order.
  function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
    case (op)
      2'd0:    return {1'b0, 4'd1};
      2'd1:    return {1'b0, 4'd2};
      2'd2:    return {1'b0, 4'd12};
      default: begin
        if (f < 6'd12) return {1'b0, 4'(f + 6'd3)};
        else           return {1'b1, 4'd0};
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] code);
    if (code == 4'd5)                     return MUL_C;
    else if (code == 4'd6 || code == 4'd13) return DIV_C;
    else                                  return 1;
  endfunction

  task automatic model_reset();
    m_has = 1'b0;
    m_ill = 1'b0;
    m_rem = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model across the rising edge.
  task automatic cyc(input logic v, input logic [1:0] op, input logic [5:0] f,
                     input logic ordy, input logic fl, input string tag);
    logic       exp_rdy;
    logic       exp_val;
    logic       exp_busy;
    logic [4:0] d;
    @(negedge clk);
    in_valid  = v;
    alu_op    = op;
    funct     = f;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_val  = m_has && (m_rem == 0);
    exp_busy = m_has && (m_rem > 0);
    exp_rdy  = !fl && (!m_has || (m_rem == 0 && ordy));
    check({tag, ".in_ready"},  in_ready,  exp_rdy);
    check({tag, ".out_valid"}, out_valid, exp_val);
    check({tag, ".busy"},      busy,      exp_busy);
    check({tag, ".illegal"},   illegal,   m_ill);
    if (exp_val) check({tag, ".alu_control"}, alu_control, m_code);
    if (busy) busy_seen++;
    if (out_valid) valid_seen++;
    @(posedge clk);
    if (fl) begin
      model_reset();
    end else if (v && exp_rdy) begin
      d      = ref_decode(op, f);
      m_has  = 1'b1;
      m_code = d[3:0];
      m_ill  = d[4];
      m_rem  = ref_latency(d[3:0]) - 1;
    end else if (m_has && m_rem > 0) begin
      m_rem--;
    end else if (m_has && ordy) begin
      m_has = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst.out_valid",   out_valid,   1'b0);
    check("rst.busy",        busy,        1'b0);
    check("rst.illegal",     illegal,     1'b0);
    check("rst.alu_control", alu_control, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready_after_release", in_ready, 1'b1);

    // Single-cycle add via alu_op 00
    cyc(1'b1, 2'd0, 6'd0, 1'b1, 1'b0, "add_accept");
    cyc(1'b0, 2'd0, 6'd0, 1'b1, 1'b0, "add_result");
    cyc(1'b0, 2'd0, 6'd0, 1'b1, 1'b0, "add_idle");

    // Divide: 7 busy cycles then one valid cycle
    busy_seen  = 0;
    valid_seen = 0;
    cyc(1'b1, 2'd3, 6'd3, 1'b1, 1'b0, "div_accept");
    for (int i = 0; i < 8; i++) cyc(1'b0, 2'd3, 6'(i), 1'b1, 1'b0, "div_wait");
    check("div.busy_cycles",  busy_seen,  7);
    check("div.valid_cycles", valid_seen, 1);
    cyc(1'b0, 2'd0, 6'd0, 1'b1, 1'b0, "div_idle");

    // Four back-to-back single-cycle ops: or, and, xor, sll
    valid_seen = 0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'd3, 6'(4 + i), 1'b1, 1'b0, "b2b");
    cyc(1'b0, 2'd0, 6'd0, 1'b1, 1'b0, "b2b_last");
    cyc(1'b0, 2'd0, 6'd0, 1'b1, 1'b0, "b2b_idle");
    check("b2b.valid_cycles", valid_seen, 4);

    // Illegal funct held with out_ready low; input changes must be ignored
    cyc(1'b1, 2'd3, 6'd63, 1'b0, 1'b0, "ill_accept");
    cyc(1'b1, 2'd3, 6'd2,  1'b0, 1'b0, "ill_hold0");
    cyc(1'b1, 2'd0, 6'd5,  1'b0, 1'b0, "ill_hold1");
    cyc(1'b1, 2'd1, 6'd9,  1'b0, 1'b0, "ill_hold2");
    cyc(1'b0, 2'd0, 6'd0,  1'b1, 1'b0, "ill_take");
    cyc(1'b0, 2'd0, 6'd0,  1'b1, 1'b0, "ill_idle");

    // Multiply flushed on its second MULTI cycle, then a new add
    valid_seen = 0;
    cyc(1'b1, 2'd3, 6'd2, 1'b1, 1'b0, "mul_accept");
    cyc(1'b0, 2'd3, 6'd2, 1'b1, 1'b0, "mul_multi1");
    cyc(1'b1, 2'd0, 6'd0, 1'b1, 1'b1, "mul_flush");
    cyc(1'b1, 2'd3, 6'd0, 1'b1, 1'b0, "post_flush_add");
    cyc(1'b0, 2'd0, 6'd0, 1'b1, 1'b0, "post_flush_res");
    check("flush.valid_cycles", valid_seen, 1);

    // Reset asserted in the middle of a divide
    cyc(1'b1, 2'd3, 6'd10, 1'b1, 1'b0, "rem_accept");
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 6'd0, 1'b1, 1'b0, "rem_wait");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid",   out_valid,   1'b0);
    check("midrst.busy",        busy,        1'b0);
    check("midrst.illegal",     illegal,     1'b0);
    check("midrst.alu_control", alu_control, 4'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst.in_ready_after_release", in_ready, 1'b1);
    valid_seen = 0;
    for (int i = 0; i < 10; i++) cyc(1'b0, 2'd0, 6'd0, 1'b1, 1'b0, "midrst_quiet");
    check("midrst.no_stale_result", valid_seen, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)),
          6'($urandom_range(0, 15)),
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 24) == 0),
          "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  FUNCT_W, 6, funct field width;
  OP_W, 2, ALU_Op width;
  CTRL_W, 4, ALU control code width;
  MUL_CYCLES, 4, multiply latency in cycles, >=1;
  DIV_CYCLES, 8, divide/remainder latency in cycles, >=1.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk, in, 1, single clock, rising edge;
  rst_n, in, 1, asynchronous active-low reset;
  flush, in, 1, synchronous pipeline flush;
  in_valid, in, 1, decode request valid;
  in_ready, out, 1, request accepted when in_valid&&in_ready;
  alu_op, in, OP_W, main-decoder ALU op;
  funct, in, FUNCT_W, instruction funct field;
  out_valid, out, 1, alu_control valid for consumption;
  out_ready, in, 1, consumer takes result when out_valid&&out_ready;
  alu_control, out, CTRL_W, registered ALU control code;
  illegal, out, 1, registered flag: undefined funct;
  busy, out, 1, multi-cycle operation in progress (stall request).
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 Decode: alu_op 00->0001 (add), 01->0010 (sub), 10->1100 (slt); for alu_op 11, funct 0..11 SHALL map to 0011 add, 0100 sub, 0101 mul, 0110 div, 0111 or, 1000 and, 1001 xor, 1010 sll, 1011 srl, 1100 slt, 1101 rem, 1110 sra.
REQ-005 alu_op 11 with funct >11 SHALL yield alu_control 0000 and illegal=1; illegal SHALL be 0 for every other decode.
REQ-006 Latency class: 0101 uses MUL_CYCLES; 0110 and 1101 use DIV_CYCLES; all others are single-cycle.
REQ-007 FSM states SHALL be IDLE, MULTI, ISSUE.
REQ-008 IDLE: in_ready=1; on accept, alu_control/illegal SHALL be registered at that edge; next state ISSUE if the latency is 1, else MULTI with counter loaded to latency-2.
REQ-009 MULTI: busy=1, in_ready=0, out_valid=0; counter decrements each cycle; at counter==0 next state ISSUE.
REQ-010 ISSUE: out_valid=1, busy=0; alu_control and illegal SHALL stay stable until out_ready=1.
REQ-011 ISSUE: in_ready SHALL equal out_ready; a simultaneous handoff and accept SHALL load the new decode with no bubble (back-to-back single-cycle ops: one result per cycle).
REQ-012 ISSUE with out_ready=1 and no accept SHALL return to IDLE with out_valid=0 next cycle.
REQ-013 Latency: a result SHALL become out_valid exactly L cycles after the accept edge, where L is the op latency (single-cycle: 1).
REQ-014 flush=1 SHALL force IDLE, out_valid=0, busy=0, illegal=0 at the next edge from any state; flush SHALL override a same-cycle accept, and in_ready SHALL be 0 while flush=1.
REQ-015 Counter width SHALL be $clog2(max(MUL_CYCLES,DIV_CYCLES)+1); the counter SHALL never wrap below 0.
REQ-016 alu_op/funct SHALL be sampled only on accept; changes at any other time SHALL have no effect.

Reset
REQ-017 While rst_n=0: state=IDLE, counter=0, alu_control=0000, out_valid=0, illegal=0, busy=0; in_ready SHALL be 1 immediately after deassertion.
REQ-018 Reset asserted mid-MULTI SHALL abandon the operation with no out_valid pulse.

Structure
REQ-019 Shared package alu_pkg SHALL hold the ALU control code enum, ALU_Op constants, funct constants and the latency-class function.
REQ-020 Decode SHALL be a combinational sub-module alu_ctrl_lut (alu_op, funct -> code, illegal, latency class); the FSM, counter and output registers live in alu_op_sequencer.

Verification
REQ-021 alu_op=00 accepted, out_ready=1 -> next cycle out_valid=1, alu_control=0001, busy=0.
REQ-022 alu_op=11, funct=000011 (div), DIV_CYCLES=8 -> busy=1 for 7 cycles, out_valid=1 on the 8th cycle with alu_control=0110.
REQ-023 Four back-to-back single-cycle ops (or, and, xor, sll), out_ready=1 -> four consecutive out_valid cycles: 0111, 1000, 1001, 1010.
REQ-024 funct=111111 with alu_op=11 -> alu_control=0000, illegal=1; hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
REQ-025 mul accepted, flush at cycle 2 of MULTI -> next cycle IDLE, busy=0, no out_valid; a new add is accepted the following cycle.
REQ-026 rst_n pulsed low mid-div -> all outputs 0 asynchronously, in_ready=1 after release, no stale result.
